// File: rtl/rx_frame_ctrl.sv
// Receive-path sequencer: start detection, mid-bit sampling, shift strobes and frame-complete strobe.
// Optional even-parity checking is enabled by defining RX_PARITY_EN.
module rx_frame_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic serialIn,
    output logic shiftEn,
    output logic sampledBit,
    output logic charReceived,
    output logic framingError,
    output logic parityError,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef RX_PARITY_EN
    // parityError must land on the stop-sample cycle, so it is registered one count earlier
    localparam logic [CNT_W-1:0] CNT_PERR = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;
`endif

    state_t           state;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] bit_idx;

`ifdef RX_PARITY_EN
    logic par_acc;
    logic par_mis;
`endif

    // Two-flop synchronizer, preset to the idle-high line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serialIn};
        end
    end

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shiftEn      <= 1'b0;
            sampledBit   <= 1'b0;
            charReceived <= 1'b0;
            framingError <= 1'b0;
            busy         <= 1'b0;
`ifdef RX_PARITY_EN
            parityError  <= 1'b0;
            par_acc      <= 1'b0;
            par_mis      <= 1'b0;
`endif
        end else begin
            shiftEn      <= 1'b0;
            charReceived <= 1'b0;
            framingError <= 1'b0;
`ifdef RX_PARITY_EN
            parityError  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (!rxs) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end

                // Re-check the line at the middle of the start bit to reject glitches
                ST_START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
`ifdef RX_PARITY_EN
                            par_acc <= 1'b0;
                            par_mis <= 1'b0;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt    <= '0;
                        shiftEn    <= 1'b1;
                        sampledBit <= rxs;
                        bit_idx    <= bit_idx + 1'b1;
`ifdef RX_PARITY_EN
                        par_acc    <= par_acc ^ rxs;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_PARITY;
                        end
`else
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        par_mis <= (rxs != par_acc);
                        state   <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            charReceived <= 1'b1;
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                        end else begin
                            framingError <= 1'b1;
                            state        <= ST_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef RX_PARITY_EN
                        if (bit_cnt == CNT_PERR && par_mis) begin
                            parityError <= 1'b1;
                        end
`endif
                    end
                end

                // Require half a bit of continuous idle before re-arming start detection
                ST_BREAK: begin
                    if (!rxs) begin
                        bit_cnt <= '0;
                    end else if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef RX_PARITY_EN
    assign parityError = 1'b0;
`endif

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Sequencing controller for the Lab4 serial receive path.
- Watches the raw serial line, detects start bits, and times mid-bit sampling with an oversampled bit counter.
- Emits one shift strobe per data bit into the serial-to-parallel shift register.
- After a valid stop bit, issues the single-cycle charReceived strobe that loads the parallel output register.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame, LSB first; range 5 to 9.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- serialIn  input  1  raw asynchronous serial line; idle high.
- shiftEn  output  1  one-cycle strobe: shift register captures sampledBit.
- sampledBit  output  1  synchronized line value, valid while shiftEn = 1.
- charReceived  output  1  one-cycle strobe: frame complete, stop bit valid.
- framingError  output  1  one-cycle strobe: stop bit sampled low.
- parityError  output  1  one-cycle strobe: parity mismatch (PARITY_EN only).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs 0.
  - State IDLE; counters 0.
  - Synchronizer flops preset to 1.
- Input synchronization:
  - serialIn passes through a 2-flop synchronizer; the result is rxs.
  - All decisions use rxs, so latency from serialIn to rxs is 2 cycles.
- bitCnt:
  - Width clog2(CLKS_PER_BIT).
  - Clears on every state transition and otherwise increments each cycle.
- States:
  - IDLE:
    - Entered from reset or after a frame.
    - rxs = 0 -> START, bitCnt = 0.
  - START:
    - When bitCnt = CLKS_PER_BIT/2 - 1, sample rxs.
    - rxs = 0 -> DATA (bitIdx = 0).
    - rxs = 1 -> IDLE as a glitch; no strobe is issued.
  - DATA:
    - When bitCnt = CLKS_PER_BIT - 1:
      - Drive shiftEn = 1 and sampledBit = rxs for exactly one cycle.
      - Increment bitIdx.
    - After sample DATA_BITS -> STOP (or PARITY when PARITY_EN is defined).
  - STOP:
    - When bitCnt = CLKS_PER_BIT - 1, sample rxs.
    - rxs = 1: pulse charReceived the following cycle, then -> IDLE.
    - rxs = 0: pulse framingError, no charReceived, then -> BREAK.
  - BREAK:
    - Wait until rxs = 1 for CLKS_PER_BIT/2 consecutive cycles, then -> IDLE.
    - Prevents a held-low line from retriggering frames.
- Strobes:
  - shiftEn, charReceived, framingError and parityError are each at most one cycle wide.
  - No two of them are ever asserted in the same cycle.
- charReceived timing:
  - Asserted the cycle after the stop sample.
  - By then the shift register holds the final data bit, having shifted on the last shiftEn at least CLKS_PER_BIT cycles earlier.
- Reset mid-frame: immediate return to IDLE; any partial frame is discarded without strobes.
- Back-to-back frames:
  - IDLE is re-entered one cycle after the stop sample.
  - A start edge arriving during or immediately after stop is accepted with no lost cycles.
- bitIdx width: clog2(DATA_BITS + 1); it must not wrap within a frame.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA, with sampling at bitCnt = CLKS_PER_BIT - 1.
  - The received bit is checked against even parity (XOR of the data bits accumulated at each shiftEn).
  - On mismatch, parityError pulses one cycle concurrent with the stop sample. The frame still proceeds to STOP, and charReceived is still issued if the stop bit is valid.
  - No shiftEn is issued for the parity bit.
- Undefined:
  - No PARITY state and no parity accumulator.
  - parityError is tied to 0.

Test Plan:
- Reset held (reset = 0) while serialIn toggles -> all outputs 0, busy = 0; after release, line idle high -> no strobes for 100 cycles.
- Frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) at CLKS_PER_BIT = 16 -> 8 shiftEn pulses 16 cycles apart, sampledBit sequence 1,0,1,0,1,0,1,0, then one charReceived; framingError = 0.
- Low glitch of 4 cycles on the idle line -> START aborts, busy returns to 0, no shiftEn.
- Frame 0xA3 with stop bit forced 0, line then held low for 50 cycles -> framingError one pulse, no charReceived, no new START until the line is high 8 cycles.
- reset pulsed low after the 3rd shiftEn of a frame -> immediate IDLE, no further strobes; the next clean frame 0x0F receives correctly.
- With RX_PARITY_EN: 0x07 sent with parity bit 0 -> parityError pulse plus charReceived; the same frame with parity bit 1 -> charReceived only.
